// File: rtl/phase_diff_pkg.sv
// phase_diff_pkg: shared widths, FSM state type and the channel-pair table
// for the pairwise phase-difference engine.
package phase_diff_pkg;

  localparam int PHASE_W   = 16;
  localparam int NUM_CH    = 4;
  localparam int NUM_PAIRS = 6;
  localparam int K_W       = 3;   // pair index width, covers 0..5
  localparam int CH_W      = 2;   // channel index width, covers 0..3

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    UPDATE
  } state_e;

  // Pair k computes phase[PAIR_A[k]] - phase[PAIR_B[k]] (0-based channels):
  //   A = {0,0,0,1,1,2}, B = {1,2,3,2,3,3}
  function automatic logic [CH_W-1:0] pair_a(input logic [K_W-1:0] k);
    case (k)
      3'd0, 3'd1, 3'd2: pair_a = 2'd0;
      3'd3, 3'd4:       pair_a = 2'd1;
      3'd5:             pair_a = 2'd2;
      default:          pair_a = 2'd0;
    endcase
  endfunction

  function automatic logic [CH_W-1:0] pair_b(input logic [K_W-1:0] k);
    case (k)
      3'd0:             pair_b = 2'd1;
      3'd1, 3'd3:       pair_b = 2'd2;
      3'd2, 3'd4, 3'd5: pair_b = 2'd3;
      default:          pair_b = 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/phase_wrap_sub.sv
// phase_wrap_sub: combinational wrapped phase difference y = a - b.
// The difference is formed at PHASE_W+1 bits and truncated back to PHASE_W,
// which is a modulo-2*pi wrap into [-pi, pi) with no saturation.
// Ports:
//   a_i  PHASE_W signed minuend phase
//   b_i  PHASE_W signed subtrahend phase
//   y_o  PHASE_W signed wrapped difference
module phase_wrap_sub
  import phase_diff_pkg::*;
(
  input  logic signed [PHASE_W-1:0] a_i,
  input  logic signed [PHASE_W-1:0] b_i,
  output logic signed [PHASE_W-1:0] y_o
);

  logic signed [PHASE_W:0] diff_full;

  assign diff_full = {a_i[PHASE_W-1], a_i} - {b_i[PHASE_W-1], b_i};

  // Dropping the top bit is the wrap; the sign of the result is bit PHASE_W-1.
  assign y_o = diff_full[PHASE_W-1:0];

  // Top bit is intentionally discarded; fold it in so nothing is left dangling.
  logic unused_msb;
  assign unused_msb = diff_full[PHASE_W];

endmodule

// File: rtl/phase_diff.sv
// phase_diff: six wrapped inter-channel phase differences for a
// four-hydrophone array, using one shared subtractor over six cycles.
// A strobe latches the four phases, CALC walks pairs 0..5 into a shadow
// bank, UPDATE copies the bank to the outputs in one edge (strobe at E,
// outputs change at E+7). Strobes while busy are dropped.
// Ports:
//   clock           rising-edge clock
//   reset           synchronous active-high reset
//   enable          single-cycle start strobe, phases sampled on same edge
//   phase1..phase4  16-bit signed per-channel phase (32768 = pi)
//   angle1..angle6  16-bit signed registered differences:
//                   p1-p2, p1-p3, p1-p4, p2-p3, p2-p4, p3-p4
module phase_diff
  import phase_diff_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [PHASE_W-1:0] phase1,
  input  logic signed [PHASE_W-1:0] phase2,
  input  logic signed [PHASE_W-1:0] phase3,
  input  logic signed [PHASE_W-1:0] phase4,
  output logic signed [PHASE_W-1:0] angle1,
  output logic signed [PHASE_W-1:0] angle2,
  output logic signed [PHASE_W-1:0] angle3,
  output logic signed [PHASE_W-1:0] angle4,
  output logic signed [PHASE_W-1:0] angle5,
  output logic signed [PHASE_W-1:0] angle6
);

  state_e                                state_q, state_d;
  logic [K_W-1:0]                        k_q, k_d;
  logic [NUM_CH-1:0][PHASE_W-1:0]        cap_q;
  logic [NUM_PAIRS-1:0][PHASE_W-1:0]     shadow_q;
  logic [NUM_PAIRS-1:0][PHASE_W-1:0]     angle_q;

  logic cap_en, calc_en, pub_en;
  logic signed [PHASE_W-1:0] sub_a, sub_b, sub_y;

  // Operand select for the shared subtractor from the pair table.
  assign sub_a = cap_q[pair_a(k_q)];
  assign sub_b = cap_q[pair_b(k_q)];

  phase_wrap_sub u_sub (
    .a_i (sub_a),
    .b_i (sub_b),
    .y_o (sub_y)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cap_en  = 1'b0;
    calc_en = 1'b0;
    pub_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          cap_en  = 1'b1;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        calc_en = 1'b1;
        if (k_q == K_W'(NUM_PAIRS - 1)) begin
          k_d     = '0;
          state_d = UPDATE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      UPDATE: begin
        pub_en  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        k_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cap_q    <= '0;
      shadow_q <= '0;
      angle_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (cap_en)  cap_q          <= {phase4, phase3, phase2, phase1};
      if (calc_en) shadow_q[k_q]  <= sub_y;
      if (pub_en)  angle_q        <= shadow_q;
    end
  end

  assign angle1 = angle_q[0];
  assign angle2 = angle_q[1];
  assign angle3 = angle_q[2];
  assign angle4 = angle_q[3];
  assign angle5 = angle_q[4];
  assign angle6 = angle_q[5];

endmodule

// File: tb/tb_phase_diff.sv
// tb_phase_diff: directed and random checks of phase_diff against a
// plain-integer reference of the six wrapped pairwise differences.
module tb_phase_diff;

  logic clock = 1'b0;
  logic reset, enable;
  logic signed [15:0] phase1, phase2, phase3, phase4;
  logic signed [15:0] angle1, angle2, angle3, angle4, angle5, angle6;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  phase_diff dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .phase1 (phase1),
    .phase2 (phase2),
    .phase3 (phase3),
    .phase4 (phase4),
    .angle1 (angle1),
    .angle2 (angle2),
    .angle3 (angle3),
    .angle4 (angle4),
    .angle5 (angle5),
    .angle6 (angle6)
  );

  // Reference: wrapped difference in plain integers.
  function automatic int wrapd(input int a, input int b);
    int d;
    d = a - b;
    if (d > 32767)  d -= 65536;
    if (d < -32768) d += 65536;
    return d;
  endfunction

  function automatic logic [95:0] model(input int p1, input int p2, input int p3, input int p4);
    logic [15:0] a [6];
    a[0] = 16'(wrapd(p1, p2)); a[1] = 16'(wrapd(p1, p3)); a[2] = 16'(wrapd(p1, p4));
    a[3] = 16'(wrapd(p2, p3)); a[4] = 16'(wrapd(p2, p4)); a[5] = 16'(wrapd(p3, p4));
    return {a[0], a[1], a[2], a[3], a[4], a[5]};
  endfunction

  function automatic logic [95:0] pack6(input int a1, input int a2, input int a3,
                                        input int a4, input int a5, input int a6);
    return {16'(a1), 16'(a2), 16'(a3), 16'(a4), 16'(a5), 16'(a6)};
  endfunction

  logic [95:0] cur;  // expected current output value

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] exp);
    logic [95:0] obs;
    obs = {angle1, angle2, angle3, angle4, angle5, angle6};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic junk_phases();
    phase1 = 16'($urandom); phase2 = 16'($urandom);
    phase3 = 16'($urandom); phase4 = 16'($urandom);
  endtask

  // Strobe at edge E, check hold through E+6 and the new value at E+7.
  // Returns at #1 after E+7, so a following call strobes at E+8.
  task automatic run(input string tag, input int p1, input int p2, input int p3, input int p4,
                     input logic [95:0] exp);
    phase1 = 16'(p1); phase2 = 16'(p2); phase3 = 16'(p3); phase4 = 16'(p4);
    enable = 1'b1;
    step();
    enable = 1'b0;
    junk_phases();
    for (int j = 1; j <= 6; j++) begin
      step();
      chk({tag, "_hold"}, cur);
    end
    step();
    chk({tag, "_e7"}, exp);
    cur = exp;
  endtask

  initial begin
    logic [95:0] e;
    logic [95:0] first;
    int r1, r2, r3, r4;
    reset = 1'b1; enable = 1'b0;
    phase1 = '0; phase2 = '0; phase3 = '0; phase4 = '0;
    step(); step();
    reset = 1'b0;
    cur = '0;
    chk("reset_zero", '0);

    // Test-plan vectors with literal expectations, cross-checked with model.
    e = pack6(-11969, 11520, -224, 23489, 11745, -11744);
    chk("model_vec1", model(5535, 17504, -5985, 5759) ^ e ^ {angle1, angle2, angle3, angle4, angle5, angle6});
    run("vec1", 5535, 17504, -5985, 5759, e);
    run("perm", -5985, 5759, 5535, 17504, pack6(-11744, -11520, -23489, 224, -11745, -11969));
    run("quad", 16383, 16383, -16383, 0, pack6(0, 32766, 16383, 32766, 16383, -16383));
    run("wrap", 20000, -20000, -32768, 32767, pack6(-25536, -12768, -12767, 12768, 12769, 1));
    run("extreme", -32768, 32767, 0, -32768, model(-32768, 32767, 0, -32768));

    // Strobe while busy: second enable sampled at E+3 is dropped.
    first = model(1000, -2000, 3000, -4000);
    phase1 = 16'(1000); phase2 = -16'sd2000; phase3 = 16'(3000); phase4 = -16'sd4000;
    enable = 1'b1;
    step();                     // E
    enable = 1'b0; junk_phases();
    step(); step();             // E+2
    phase1 = 16'(7); phase2 = 16'(8); phase3 = 16'(9); phase4 = 16'(10);
    enable = 1'b1;
    step();                     // E+3
    enable = 1'b0; junk_phases();
    chk("busy_hold_e3", cur);
    step(); step(); step();     // E+6
    chk("busy_hold_e6", cur);
    step();                     // E+7
    chk("busy_first_e7", first);
    cur = first;
    for (int j = 8; j <= 14; j++) begin
      step();
      chk("busy_no_second", cur);
    end

    // Reset at E+4 aborts; outputs go to 0 and stay there.
    phase1 = 16'(12345); phase2 = 16'(-321); phase3 = 16'(999); phase4 = 16'(-30000);
    enable = 1'b1;
    step();                     // E
    enable = 1'b0; junk_phases();
    step(); step(); step();     // E+3
    reset = 1'b1;
    step();                     // E+4
    reset = 1'b0;
    cur = '0;
    for (int j = 5; j <= 11; j++) begin
      step();
      chk("abort_zero", '0);
    end
    run("after_abort", 100, 200, 300, 400, model(100, 200, 300, 400));

    // Reset and enable on the same edge: strobe dropped.
    reset = 1'b1; enable = 1'b1;
    phase1 = 16'(5); phase2 = 16'(6); phase3 = 16'(7); phase4 = 16'(8);
    step();
    reset = 1'b0; enable = 1'b0;
    cur = '0;
    for (int j = 1; j <= 9; j++) begin
      step();
      chk("rst_en_drop", '0);
    end

    // Random back-to-back strobes at minimum spacing.
    for (int n = 0; n < 25; n++) begin
      r1 = int'($signed(16'($urandom))); r2 = int'($signed(16'($urandom)));
      r3 = int'($signed(16'($urandom))); r4 = int'($signed(16'($urandom)));
      run("rand", r1, r2, r3, r4, model(r1, r2, r3, r4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
